// File: rtl/branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// Module   : branch_resolve_unit
// Purpose  : Update-side partner of the 2-bit BHT/BTB predictor. Records each
//            fetched branch's prediction in an in-order in-flight queue. When
//            execute resolves the oldest branch, the unit compares prediction
//            and outcome, drives the predictor update port, and on a
//            misprediction issues a one-cycle flush with a redirect PC.
// Ports    : clk, rst_n (async, active-low)
//            fetch_*   - push side (fetch stage), q_full / q_count status
//            resolve_* - resolve side (execute stage, oldest branch first)
//            update_en, pc_resolve, taken, target - predictor update
//            flush, redirect_pc - misprediction recovery
//            branch_cnt, mispredict_cnt - saturating statistics
//            proto_err - sticky: resolve seen with an empty queue
// Revision : 1.0 - initial release
// ============================================================================
module branch_resolve_unit #(
    parameter int          DEPTH  = 4,
    parameter int          PTR    = 2,
    parameter logic [15:0] PC_INC = 16'd2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           fetch_push,
    input  logic [15:0]    fetch_pc,
    input  logic           fetch_pred_taken,
    input  logic [15:0]    fetch_pred_target,
    output logic           q_full,
    output logic [PTR:0]   q_count,
    input  logic           resolve_valid,
    input  logic           resolve_taken,
    input  logic [15:0]    resolve_target,
    output logic           update_en,
    output logic [15:0]    pc_resolve,
    output logic           taken,
    output logic [15:0]    target,
    output logic           flush,
    output logic [15:0]    redirect_pc,
    output logic [15:0]    branch_cnt,
    output logic [15:0]    mispredict_cnt,
    output logic           proto_err
);

    localparam logic [PTR:0] c_full_cnt = (PTR+1)'(DEPTH);

    // Record storage (no reset needed: validity is tracked by the pointers)
    logic [15:0]    r_q_pc   [DEPTH];
    logic           r_q_pt   [DEPTH];
    logic [15:0]    r_q_tgt  [DEPTH];

    logic [PTR-1:0] r_wr_ptr;
    logic [PTR-1:0] r_rd_ptr;
    logic [PTR:0]   r_count;

    logic           r_update_en;
    logic [15:0]    r_pc_resolve;
    logic           r_taken;
    logic [15:0]    r_target;
    logic           r_flush;
    logic [15:0]    r_redirect_pc;
    logic [15:0]    r_branch_cnt;
    logic [15:0]    r_mispredict_cnt;
    logic           r_proto_err;

    logic           w_full;
    logic           w_empty;
    logic           w_push_ok;
    logic           w_res_ok;
    logic           w_mispredict;
    logic [15:0]    w_head_pc;
    logic           w_head_pt;
    logic [15:0]    w_head_tgt;

    assign w_full     = (r_count == c_full_cnt);
    assign w_empty    = (r_count == '0);
    assign w_head_pc  = r_q_pc[r_rd_ptr];
    assign w_head_pt  = r_q_pt[r_rd_ptr];
    assign w_head_tgt = r_q_tgt[r_rd_ptr];

    // While flush is high the fetch stream is wrong-path, so pushes are dropped
    assign w_push_ok  = fetch_push & ~w_full & ~r_flush;
    assign w_res_ok   = resolve_valid & ~w_empty;

    // Not-taken/not-taken is always correct; targets only matter when both taken
    assign w_mispredict = w_res_ok &
                          ((w_head_pt != resolve_taken) |
                           (w_head_pt & resolve_taken & (w_head_tgt != resolve_target)));

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_q_pc[r_wr_ptr]  <= fetch_pc;
            r_q_pt[r_wr_ptr]  <= fetch_pred_taken;
            r_q_tgt[r_wr_ptr] <= fetch_pred_target;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (w_mispredict) begin
            // Every younger record is wrong-path; a same-cycle push is discarded too
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_res_ok) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push_ok, w_res_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_update_en      <= 1'b0;
            r_pc_resolve     <= 16'h0000;
            r_taken          <= 1'b0;
            r_target         <= 16'h0000;
            r_flush          <= 1'b0;
            r_redirect_pc    <= 16'h0000;
            r_branch_cnt     <= 16'h0000;
            r_mispredict_cnt <= 16'h0000;
            r_proto_err      <= 1'b0;
        end else begin
            r_update_en <= w_res_ok;
            r_flush     <= w_mispredict;
            if (resolve_valid && w_empty) begin
                r_proto_err <= 1'b1;
            end
            if (w_res_ok) begin
                r_pc_resolve <= w_head_pc;
                r_taken      <= resolve_taken;
                r_target     <= resolve_target;
                if (r_branch_cnt != 16'hFFFF) begin
                    r_branch_cnt <= r_branch_cnt + 16'd1;
                end
            end
            if (w_mispredict) begin
                r_redirect_pc <= resolve_taken ? resolve_target : (w_head_pc + PC_INC);
                if (r_mispredict_cnt != 16'hFFFF) begin
                    r_mispredict_cnt <= r_mispredict_cnt + 16'd1;
                end
            end
        end
    end

    assign q_full         = w_full;
    assign q_count        = r_count;
    assign update_en      = r_update_en;
    assign pc_resolve     = r_pc_resolve;
    assign taken          = r_taken;
    assign target         = r_target;
    assign flush          = r_flush;
    assign redirect_pc    = r_redirect_pc;
    assign branch_cnt     = r_branch_cnt;
    assign mispredict_cnt = r_mispredict_cnt;
    assign proto_err      = r_proto_err;

endmodule
`default_nettype wire
